// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit sequencer: picks the winning WB exception, pulses the CSR strobes,
// then holds flush through the fetch redirect and a fixed drain. EXC_COMMIT_CNT_EN adds event counters.
module exc_commit_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc_in,
   input  logic [31:0] wb_vaddr_in,
   input  logic [4:0]  wb_exvec,
   input  logic        wb_ertn,
   input  logic        has_int,
   input  logic [31:0] ex_entry,
   input  logic [31:0] era,
   output logic        wb_commit,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_vaddr,
   output logic        ertn_flush,
   output logic        flush,
   output logic        redir_valid,
   output logic [31:0] redir_pc,
   input  logic        redir_ready
`ifdef EXC_COMMIT_CNT_EN
   ,
   output logic [31:0] exc_cnt,
   output logic [15:0] int_cnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, REDIR = 2'd1, DRAIN = 2'd2} state_t;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       idle;
   logic       take_ex;
   logic       take_ertn;

   // Interrupt outranks every synchronous flag; the rest follow fetch-to-memory order.
   function automatic logic [5:0] sel_ecode(input logic intr, input logic [4:0] exv);
      logic [5:0] code;
      if (intr)        code = 6'h00;
      else if (exv[0]) code = 6'h08;
      else if (exv[1]) code = 6'h0D;
      else if (exv[2]) code = 6'h0B;
      else if (exv[3]) code = 6'h0C;
      else             code = 6'h09;
      return code;
   endfunction

`ifdef EXC_COMMIT_CNT_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   assign idle      = (state == IDLE);
   assign take_ex   = idle & wb_valid & (has_int | (|wb_exvec));
   assign take_ertn = idle & wb_valid & wb_ertn & ~take_ex;
   assign wb_commit = wb_valid & idle & ~take_ex;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         wb_ex       <= 1'b0;
         wb_ecode    <= '0;
         wb_esubcode <= '0;
         wb_pc       <= '0;
         wb_vaddr    <= '0;
         ertn_flush  <= 1'b0;
         flush       <= 1'b0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
      end else begin
         wb_ex      <= 1'b0;
         ertn_flush <= 1'b0;
         case (state)
            IDLE: begin
               if (take_ex) begin
                  wb_ex       <= 1'b1;
                  wb_ecode    <= sel_ecode(has_int, wb_exvec);
                  wb_esubcode <= '0;
                  wb_pc       <= wb_pc_in;
                  wb_vaddr    <= wb_vaddr_in;
                  redir_pc    <= ex_entry;
                  redir_valid <= 1'b1;
                  flush       <= 1'b1;
                  state       <= REDIR;
               end else if (take_ertn) begin
                  ertn_flush  <= 1'b1;
                  redir_pc    <= era;
                  redir_valid <= 1'b1;
                  flush       <= 1'b1;
                  state       <= REDIR;
               end
            end
            REDIR: begin
               if (redir_ready) begin
                  redir_valid <= 1'b0;
                  cnt         <= CNT_INIT;
                  state       <= DRAIN;
               end
            end
            default: begin
               if (cnt == 4'd0) begin
                  flush <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase
      end
   end

`ifdef EXC_COMMIT_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_cnt <= '0;
         int_cnt <= '0;
      end else if (take_ex) begin
         exc_cnt <= sat_inc32(exc_cnt);
         if (has_int) int_cnt <= sat_inc16(int_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: a phase-level reference model queues expected
// strobes and per-cycle levels; a negedge monitor pops and compares them.
module tb_exc_commit_ctrl;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_pc_in = '0;
   logic [31:0] wb_vaddr_in = '0;
   logic [4:0]  wb_exvec = '0;
   logic        wb_ertn = 1'b0;
   logic        has_int = 1'b0;
   logic [31:0] ex_entry = '0;
   logic [31:0] era = '0;
   logic        redir_ready = 1'b0;
   logic        wb_commit, wb_ex, ertn_flush, flush, redir_valid;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr, redir_pc;
`ifdef EXC_COMMIT_CNT_EN
   logic [31:0] exc_cnt;
   logic [15:0] int_cnt;
`endif

   exc_commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
      .wb_vaddr_in(wb_vaddr_in), .wb_exvec(wb_exvec), .wb_ertn(wb_ertn),
      .has_int(has_int), .ex_entry(ex_entry), .era(era), .wb_commit(wb_commit),
      .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .flush(flush),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
`ifdef EXC_COMMIT_CNT_EN
      , .exc_cnt(exc_cnt), .int_cnt(int_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [2:0]  kind;   // {ertn_flush, wb_ex, wb_commit}
      logic [5:0]  ecode;
      logic [31:0] pc;
      logic [31:0] vaddr;
   } evt_t;

   typedef struct {
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic [5:0]  ecode;
      logic [31:0] pc;
      logic [31:0] vaddr;
      logic [31:0] exc;
      logic [15:0] intc;
   } lvl_t;

   evt_t evt_q[$];
   lvl_t lvl_q[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: "redirect pending" flag plus a count of drain cycles still owed.
   bit          m_pend = 0;
   int          m_drain = 0;
   logic [31:0] m_rpc = '0, m_pc = '0, m_va = '0, m_exc = '0;
   logic [5:0]  m_ec = '0;
   logic [15:0] m_int = '0;
   logic [31:0] g_entry = 32'h1C00_8000;
   logic [31:0] g_era = 32'h1C00_0200;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [5:0] ref_ecode(input logic hi, input logic [4:0] ev);
      logic [5:0] code [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      if (hi) return 6'h00;
      for (int i = 0; i < 5; i++)
         if (ev[i]) return code[i];
      return 6'h00;
   endfunction

   task automatic model_eval();
      lvl_t l;
      evt_t e;
      l = '{default: '0};
      e = '{default: '0};
      if (!resetn) begin
         m_pend = 0; m_drain = 0; m_rpc = '0; m_pc = '0; m_va = '0;
         m_ec = '0; m_exc = '0; m_int = '0;
         lvl_q.push_back(l);
         return;
      end
      l.flush = m_pend || (m_drain > 0);
      l.rv = m_pend;
      l.rpc = m_rpc; l.ecode = m_ec; l.pc = m_pc; l.vaddr = m_va;
      l.exc = m_exc; l.intc = m_int;
      lvl_q.push_back(l);
      if (!m_pend && m_drain == 0) begin
         if (wb_valid && (has_int || wb_exvec != 0)) begin
            e.cyc = cyc + 1; e.kind = 3'b010; e.ecode = ref_ecode(has_int, wb_exvec);
            e.pc = wb_pc_in; e.vaddr = wb_vaddr_in;
            evt_q.push_back(e);
            m_ec = e.ecode; m_pc = wb_pc_in; m_va = wb_vaddr_in; m_rpc = ex_entry;
            m_pend = 1;
            if (m_exc != 32'hFFFF_FFFF) m_exc = m_exc + 1;
            if (has_int && m_int != 16'hFFFF) m_int = m_int + 1;
         end else if (wb_valid) begin
            e.cyc = cyc; e.kind = 3'b001;
            evt_q.push_back(e);
            if (wb_ertn) begin
               e.cyc = cyc + 1; e.kind = 3'b100;
               evt_q.push_back(e);
               m_rpc = era;
               m_pend = 1;
            end
         end
      end else if (m_pend) begin
         if (redir_ready) begin
            m_pend = 0;
            m_drain = FC;
         end
      end else begin
         m_drain--;
      end
   endtask

   task automatic step(input logic rst_v, input logic v, input logic [31:0] pc,
                       input logic [31:0] va, input logic [4:0] ev, input logic er,
                       input logic hi, input logic rdy);
      @(posedge clk);
      #1;
      resetn = rst_v; wb_valid = v; wb_pc_in = pc; wb_vaddr_in = va; wb_exvec = ev;
      wb_ertn = er; has_int = hi; redir_ready = rdy; ex_entry = g_entry; era = g_era;
      model_eval();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, rdy);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #1;
      wb_valid = 1'b0; wb_exvec = '0; wb_ertn = 1'b0; has_int = 1'b0; redir_ready = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_flush", {31'b0, flush}, 32'd0);
      chk("async_rst_redir_valid", {31'b0, redir_valid}, 32'd0);
      chk("async_rst_wb_ex", {31'b0, wb_ex}, 32'd0);
      evt_q.delete();
      model_eval();
   endtask

   always @(negedge clk) begin : monitor
      lvl_t l;
      evt_t e;
      logic [2:0] obs;
      if (lvl_q.size() > 0) begin
         l = lvl_q.pop_front();
         chk("flush", {31'b0, flush}, {31'b0, l.flush});
         chk("redir_valid", {31'b0, redir_valid}, {31'b0, l.rv});
         chk("redir_pc", redir_pc, l.rpc);
         chk("wb_ecode_hold", {26'b0, wb_ecode}, {26'b0, l.ecode});
         chk("wb_pc_hold", wb_pc, l.pc);
         chk("wb_vaddr_hold", wb_vaddr, l.vaddr);
`ifdef EXC_COMMIT_CNT_EN
         chk("exc_cnt", exc_cnt, l.exc);
         chk("int_cnt", {16'b0, int_cnt}, {16'b0, l.intc});
`endif
      end
      obs = {ertn_flush, wb_ex, wb_commit};
      while (evt_q.size() > 0 && evt_q[0].cyc < cyc) begin
         e = evt_q.pop_front();
         total++; bad++;
         $display("FAIL missed_event actual=none required=%b cyc=%0d", e.kind, e.cyc);
      end
      if (evt_q.size() > 0 && evt_q[0].cyc == cyc) begin
         e = evt_q.pop_front();
         chk("event_kind", {29'b0, obs}, {29'b0, e.kind});
         if (e.kind == 3'b010) begin
            chk("ex_ecode", {26'b0, wb_ecode}, {26'b0, e.ecode});
            chk("ex_esubcode", {23'b0, wb_esubcode}, 32'd0);
            chk("ex_pc", wb_pc, e.pc);
            chk("ex_vaddr", wb_vaddr, e.vaddr);
         end
      end else begin
         chk("no_event", {29'b0, obs}, 32'd0);
      end
   end

   initial begin
      // Reset held low from time zero; registered outputs must all read zero.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b1);
      // SYS with immediate redirect acceptance.
      step(1'b1, 1'b1, 32'h1C00_0100, 32'h0, 5'b00100, 1'b0, 1'b0, 1'b1);
      idle(6, 1'b1);
      // INE+ALE with and without a pending interrupt.
      step(1'b1, 1'b1, 32'h1C00_0110, 32'h10, 5'b10010, 1'b0, 1'b1, 1'b1);
      idle(6, 1'b1);
      step(1'b1, 1'b1, 32'h1C00_0120, 32'h20, 5'b10010, 1'b0, 1'b0, 1'b1);
      idle(6, 1'b1);
      // ERTN with fetch stalled; a SYS arriving during REDIR must be ignored.
      g_era = 32'h1C00_0200;
      step(1'b1, 1'b1, 32'h1C00_0130, 32'h0, 5'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h1C00_0140, 32'h0, 5'b00100, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
      idle(6, 1'b1);
      // ERTN and ALE together: exception wins.
      step(1'b1, 1'b1, 32'h1C00_0150, 32'h8000_00F3, 5'b10000, 1'b1, 1'b0, 1'b1);
      idle(6, 1'b1);
      // Asynchronous reset in the middle of a stalled redirect.
      step(1'b1, 1'b1, 32'h1C00_0160, 32'h0, 5'b01000, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      async_reset();
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b1);
      step(1'b1, 1'b1, 32'h1C00_0170, 32'h0, 5'b0, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] ev;
         g_entry = $urandom;
         g_era = $urandom;
         ev = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         step(1'b1, ($urandom_range(0, 3) != 0), $urandom, $urandom, ev,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 1) == 1));
      end
      idle(25, 1'b1);
      @(negedge clk);
      #1;
      chk("events_drained", evt_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Exception/ERTN commit sequencer between the WB stage and the CSR file.
- Prioritises the WB-stage exception flags and the CSR interrupt request, and drives the CSR commit strobes: wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush.
- Holds a pipeline-wide flush until the fetch stage accepts the redirect to the exception entry or ERA, then drains for a fixed number of cycles before accepting new commits.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after the redirect handshake; legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- wb_valid  in  1  valid instruction in WB
- wb_pc_in  in  32  PC of the WB instruction
- wb_vaddr_in  in  32  data address of the WB load/store
- wb_exvec  in  5  WB exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
- wb_ertn  in  1  WB instruction is ERTN
- has_int  in  1  interrupt pending and enabled, from the CSR file
- ex_entry  in  32  exception entry, from the CSR file
- era  in  32  ERA value, from the CSR file
- wb_commit  out  1  WB instruction retires (regfile write gate); combinational
- wb_ex  out  1  exception strobe to the CSR file
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  32  PC latched for ERA/BADV
- wb_vaddr  out  32  address latched for BADV
- ertn_flush  out  1  ERTN strobe to the CSR file
- flush  out  1  squash all pipeline stages
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all registered outputs 0; drain counter 0.
- States: IDLE, REDIR, DRAIN.

Decision (IDLE only, combinational at cycle T):
- take_ex = wb_valid & (has_int | |wb_exvec).
- take_ertn = wb_valid & wb_ertn & ~take_ex. An exception beats ERTN.
- wb_commit = wb_valid & state==IDLE & ~take_ex. ERTN does commit.
- Priority, highest first:
  - INT: ecode 0x00, sub 0
  - ADEF: ecode 0x08, sub 0
  - INE: ecode 0x0D
  - SYS: ecode 0x0B
  - BRK: ecode 0x0C
  - ALE: ecode 0x09
  - Subcode is 0 for all of them.
- Interrupts are taken only on a valid WB instruction. That instruction does not retire, and its PC goes to ERA.

Edge at the end of cycle T:
- On take_ex:
  - wb_ex=1; ecode/esubcode from the winner; wb_pc=wb_pc_in; wb_vaddr=wb_vaddr_in.
  - redir_pc=ex_entry; redir_valid=1; state=REDIR.
- On take_ertn: ertn_flush=1; redir_pc=era; redir_valid=1; state=REDIR.
- Otherwise: no change.

Strobes and flush:
- wb_ex and ertn_flush are single-cycle pulses in cycle T+1; they clear at the next edge.
- wb_ecode, wb_esubcode, wb_pc and wb_vaddr hold until the next take_ex.
- flush = (state != IDLE), registered with the state, so it first goes high in T+1.

REDIR:
- redir_valid and redir_pc stay stable until redir_ready=1 is seen at an edge.
- That edge clears redir_valid, sets cnt=FLUSH_CYCLES-1 and moves to DRAIN.
- If redir_ready=1 already in T+1, DRAIN starts at T+2.

DRAIN:
- cnt decrements each cycle; at cnt==0 the next state is IDLE.
- flush therefore stays high for exactly FLUSH_CYCLES cycles after the handshake cycle.

Ignored inputs:
- In REDIR and DRAIN, wb_valid, wb_exvec, wb_ertn and has_int are ignored, and wb_commit=0.
- The first instruction is accepted in the first IDLE cycle.

Optional Feature:
- Macro: EXC_COMMIT_CNT_EN.
- Defined:
  - Adds output exc_cnt [31:0]: a saturating count of take_ex events (saturates at 0xFFFFFFFF), reset to 0.
  - Adds output int_cnt [15:0]: a saturating count of interrupt-sourced exceptions, reset to 0.
- Undefined: neither port nor counter exists.

Test Plan:
- SYS on wb_valid, wb_pc_in=0x1C000100, redir_ready=1 → T+1: wb_ex=1, ecode=0x0B, wb_pc=0x1C000100, redir_pc=ex_entry; wb_commit=0 at T; flush high T+1 through T+1+FLUSH_CYCLES; IDLE after that.
- wb_exvec=5'b10010 (INE+ALE) together with has_int=1 → ecode=0x00. Same vector without has_int → ecode=0x0D.
- ERTN with era=0x1C000200, redir_ready held 0 for 5 cycles → ertn_flush is one pulse at T+1; redir_valid/redir_pc=0x1C000200 stable for 5 cycles; a wb_valid SYS presented during REDIR produces no wb_ex.
- ERTN and ALE flags in the same cycle, wb_vaddr_in=0x800000F3 → wb_ex=1, ecode=0x09, wb_vaddr=0x800000F3, ertn_flush=0.
- resetn pulled low mid-REDIR (asynchronously, between edges) → flush, redir_valid and wb_ex drop to 0 immediately; after release, a valid non-excepting instruction gives wb_commit=1.
- With EXC_COMMIT_CNT_EN defined: 3 exceptions, one of them an interrupt → exc_cnt=3, int_cnt=1.
